uart_rx_ext: RTL and testbench

Parametrised UART receiver for the UART subsystem. It supports a runtime baud divisor, configurable data length, parity and stop bits, and three-sample majority voting per bit. It reports framing, parity, break and overrun errors. Received words are presented on a valid/ready interface with a single holding register, which feeds the RX FIFO or a CPU register directly.

---
 rtl/uart_rx_ext.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// UART receiver: 2-flop input synchroniser, three-sample majority voting per bit,
// runtime baud divisor, and a single valid/ready holding register with error flags.
module uart_rx_ext #(
  parameter int DataLength = 8,
  parameter bit Parity     = 1'b0,
  parameter bit ParityEven = 1'b0,
  parameter int StopBits   = 1,
  parameter int DivWidth   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx,
  input  logic                  i_enable,
  input  logic [DivWidth-1:0]   i_cycles_per_bit,
  output logic [DataLength-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_parity_err,
  output logic                  o_frame_err,
  output logic                  o_break,
  output logic                  o_overrun,
  output logic                  o_busy
);

  localparam int CntW = 4;
  localparam logic [DivWidth-1:0] MinDiv   = DivWidth'(8);
  localparam logic [CntW-1:0]     LastData = CntW'(DataLength - 1);
  localparam logic [CntW-1:0]     LastStop = CntW'(StopBits - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  logic                  rx_meta_reg, rx_s_reg;
  state_t                state_reg, state_next;
  logic [DivWidth-1:0]   div_reg, div_next;
  logic [DivWidth-1:0]   clk_cnt_reg, clk_cnt_next;
  logic [CntW-1:0]       bit_cnt_reg, bit_cnt_next;
  logic [DataLength-1:0] shift_reg, shift_next;
  logic                  parity_bit_reg, parity_bit_next;
  logic                  parity_err_reg, parity_err_next;
  logic                  frame_err_reg, frame_err_next;
  logic [2:0]            sample_reg;
  logic [2:0]            sample_hit;
  logic [DivWidth-1:0]   sample_pt [3];
  logic [DivWidth-1:0]   half_bit, eighth_bit;
  logic                  bit_end, vote;

  logic [DataLength-1:0] hold_data_reg, hold_data_next;
  logic                  hold_valid_reg, hold_valid_next;
  logic                  hold_perr_reg, hold_perr_next;
  logic                  hold_ferr_reg, hold_ferr_next;
  logic                  hold_brk_reg, hold_brk_next;
  logic                  overrun_reg, overrun_next;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // Sample points sit symmetrically around mid-bit, one eighth of a bit apart.
  assign half_bit     = div_reg >> 1;
  assign eighth_bit   = div_reg >> 3;
  assign sample_pt[0] = half_bit - eighth_bit;
  assign sample_pt[1] = half_bit;
  assign sample_pt[2] = half_bit + eighth_bit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sample
      assign sample_hit[gi] = (clk_cnt_reg == sample_pt[gi]);
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sample_reg <= 3'b111;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sample_hit[i]) sample_reg[i] <= rx_s_reg;
      end
    end
  end

  assign vote    = (sample_reg[0] & sample_reg[1]) | (sample_reg[0] & sample_reg[2]) |
                   (sample_reg[1] & sample_reg[2]);
  assign bit_end = (clk_cnt_reg == div_reg - DivWidth'(1));

  always_comb begin
    state_next      = state_reg;
    div_next        = div_reg;
    clk_cnt_next    = bit_end ? '0 : clk_cnt_reg + DivWidth'(1);
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    parity_bit_next = parity_bit_reg;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;
    hold_data_next  = hold_data_reg;
    hold_valid_next = hold_valid_reg & ~i_ready;
    hold_perr_next  = hold_perr_reg;
    hold_ferr_next  = hold_ferr_reg;
    hold_brk_next   = hold_brk_reg;
    overrun_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        clk_cnt_next = '0;
        if (i_enable && !rx_s_reg) begin
          state_next      = S_START;
          div_next        = (i_cycles_per_bit < MinDiv) ? MinDiv : i_cycles_per_bit;
          bit_cnt_next    = '0;
          parity_bit_next = 1'b0;
          parity_err_next = 1'b0;
          frame_err_next  = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) state_next = vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_next = {vote, shift_reg[DataLength-1:1]};
          if (bit_cnt_reg == LastData) begin
            bit_cnt_next = '0;
            state_next   = Parity ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + CntW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          parity_bit_next = vote;
          parity_err_next = ParityEven ? (^shift_reg ^ vote) : ~(^shift_reg ^ vote);
          state_next      = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (!vote) frame_err_next = 1'b1;
          if (bit_cnt_reg == LastStop) begin
            bit_cnt_next = '0;
            state_next   = S_DONE;
          end else begin
            bit_cnt_next = bit_cnt_reg + CntW'(1);
          end
        end
      end
      S_DONE: begin
        clk_cnt_next = '0;
        // A word already held and not being taken this cycle wins; the new one is lost.
        if (!hold_valid_reg || i_ready) begin
          hold_data_next  = shift_reg;
          hold_valid_next = 1'b1;
          hold_perr_next  = parity_err_reg;
          hold_ferr_next  = frame_err_reg;
          hold_brk_next   = (shift_reg == '0) && (!Parity || !parity_bit_reg) && frame_err_reg;
        end else begin
          overrun_next = 1'b1;
        end
        state_next = frame_err_reg ? S_WAIT_HIGH : S_IDLE;
      end
      S_WAIT_HIGH: begin
        clk_cnt_next = '0;
        if (rx_s_reg) state_next = S_IDLE;
      end
      default: begin
        clk_cnt_next = '0;
        state_next   = S_IDLE;
      end
    endcase

    if (!i_enable) state_next = S_IDLE;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= S_IDLE;
      div_reg        <= MinDiv;
      clk_cnt_reg    <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_bit_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      hold_data_reg  <= '0;
      hold_valid_reg <= 1'b0;
      hold_perr_reg  <= 1'b0;
      hold_ferr_reg  <= 1'b0;
      hold_brk_reg   <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      div_reg        <= div_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      parity_bit_reg <= parity_bit_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
      hold_data_reg  <= hold_data_next;
      hold_valid_reg <= hold_valid_next;
      hold_perr_reg  <= hold_perr_next;
      hold_ferr_reg  <= hold_ferr_next;
      hold_brk_reg   <= hold_brk_next;
      overrun_reg    <= overrun_next;
    end
  end

  assign o_data       = hold_data_reg;
  assign o_valid      = hold_valid_reg;
  assign o_parity_err = hold_perr_reg;
  assign o_frame_err  = hold_ferr_reg;
  assign o_break      = hold_brk_reg;
  assign o_overrun    = overrun_reg;
  assign o_busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised scoreboard bench for uart_rx_ext (8 data, even parity, 2 stop bits);
// directed scenarios first, then random frames with random divisor, gaps and backpressure.
module tb_uart_rx_ext;

  localparam int DL = 8;
  localparam bit PAR = 1'b1;
  localparam bit PEVEN = 1'b1;
  localparam int SB = 2;
  localparam int DW = 16;

  typedef struct {
    logic [DL-1:0] data;
    logic          perr;
    logic          ferr;
    logic          brk;
  } word_t;

  logic          clk = 1'b0;
  logic          i_rst, i_rx, i_enable, i_ready;
  logic [DW-1:0] i_cycles_per_bit;
  logic [DL-1:0] o_data;
  logic          o_valid, o_parity_err, o_frame_err, o_break, o_overrun, o_busy;

  word_t exp_q[$];
  word_t mon_w;
  int    checks = 0;
  int    fails = 0;
  int    overrun_seen = 0;
  int    overrun_exp = 0;
  int    ready_mode = 0;

  always #5 clk = ~clk;

  uart_rx_ext #(
    .DataLength(DL), .Parity(PAR), .ParityEven(PEVEN), .StopBits(SB), .DivWidth(DW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_rx(i_rx), .i_enable(i_enable),
    .i_cycles_per_bit(i_cycles_per_bit), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_parity_err(o_parity_err), .o_frame_err(o_frame_err),
    .o_break(o_break), .o_overrun(o_overrun), .o_busy(o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference: what the frame content means, independent of how it is sampled.
  function automatic word_t model(input logic [DL-1:0] data, input logic pbit,
                                  input logic [SB-1:0] stops);
    word_t m;
    int ones;
    ones   = $countones(data) + int'(pbit);
    m.data = data;
    m.perr = PEVEN ? (ones % 2 != 0) : (ones % 2 == 0);
    m.ferr = (stops != {SB{1'b1}});
    m.brk  = (data == '0) && (pbit == 1'b0) && m.ferr;
    return m;
  endfunction

  function automatic logic even_pbit(input logic [DL-1:0] data);
    return ^data;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DL-1:0] data, input logic pbit,
                            input logic [SB-1:0] stops, input int n_cfg,
                            input bit expect_word, input bit garble_div);
    int nb;
    nb = (n_cfg < 8) ? 8 : n_cfg;
    if (expect_word) exp_q.push_back(model(data, pbit, stops));
    i_cycles_per_bit = DW'(n_cfg);
    i_rx = 1'b0;
    tick(nb);
    if (garble_div) i_cycles_per_bit = DW'($urandom_range(0, 65535));
    for (int i = 0; i < DL; i++) begin
      i_rx = data[i];
      tick(nb);
    end
    i_rx = pbit;
    tick(nb);
    for (int i = 0; i < SB; i++) begin
      i_rx = stops[i];
      tick(nb);
    end
    i_rx = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       i_ready = 1'b0;
        1:       i_ready = 1'b1;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (!i_rst && o_overrun) overrun_seen++;
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_word: got data=%02h perr=%0b ferr=%0b brk=%0b, required no word",
                 o_data, o_parity_err, o_frame_err, o_break);
      end else begin
        mon_w = exp_q.pop_front();
        $display("rx word data=%02h perr=%0b ferr=%0b brk=%0b (expect %02h %0b %0b %0b)",
                 o_data, o_parity_err, o_frame_err, o_break,
                 mon_w.data, mon_w.perr, mon_w.ferr, mon_w.brk);
        check("word_data", 32'(o_data), 32'(mon_w.data));
        check("word_parity_err", 32'(o_parity_err), 32'(mon_w.perr));
        check("word_frame_err", 32'(o_frame_err), 32'(mon_w.ferr));
        check("word_break", 32'(o_break), 32'(mon_w.brk));
      end
    end
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, gap, nb;
    logic [DL-1:0] d;
    logic pb;
    logic [SB-1:0] st;

    i_rst = 1'b1;
    i_rx = 1'b1;
    i_enable = 1'b1;
    i_ready = 1'b0;
    i_cycles_per_bit = DW'(16);
    tick(3);
    check("reset_valid", 32'(o_valid), 0);
    check("reset_data", 32'(o_data), 0);
    check("reset_flags", {29'd0, o_parity_err, o_frame_err, o_break}, 0);
    check("reset_overrun", 32'(o_overrun), 0);
    check("reset_busy", 32'(o_busy), 0);
    i_rst = 1'b0;
    tick(20);

    // Basic frame with latency check, consumer stalled until the word appears.
    ready_mode = 0;
    send_frame(8'h55, even_pbit(8'h55), 2'b11, 16, 1'b1, 1'b0);
    tick(3);
    check("latency_valid_low", 32'(o_valid), 0);
    tick(1);
    check("latency_valid_high", 32'(o_valid), 1);
    ready_mode = 1;
    tick(1);
    tick(1);
    check("valid_cleared_by_ready", 32'(o_valid), 0);
    tick(16);

    send_frame(8'hA3, 1'b1, 2'b11, 16, 1'b1, 1'b0);
    tick(40);

    // False start: short low pulse.
    i_cycles_per_bit = DW'(16);
    i_rx = 1'b0;
    tick(4);
    i_rx = 1'b1;
    check("false_start_busy", 32'(o_busy), 1);
    tick(30);
    check("false_start_idle", 32'(o_busy), 0);
    check("false_start_no_word", 32'(o_valid), 0);

    // Backpressure: second frame is dropped with an overrun pulse.
    ready_mode = 0;
    send_frame(8'h12, even_pbit(8'h12), 2'b11, 16, 1'b1, 1'b0);
    tick(16);
    send_frame(8'h34, even_pbit(8'h34), 2'b11, 16, 1'b0, 1'b0);
    overrun_exp++;
    tick(5);
    check("overrun_held_data", 32'(o_data), 32'h12);
    check("overrun_held_valid", 32'(o_valid), 1);
    check("overrun_pulse_cycles", overrun_seen, overrun_exp);
    ready_mode = 1;
    tick(5);
    check("overrun_nothing_more", 32'(o_valid), 0);

    // Break: line held low for 20 bit times.
    exp_q.push_back(model(8'h00, 1'b0, 2'b00));
    i_rx = 1'b0;
    tick(20 * 16);
    check("break_wait_high_busy", 32'(o_busy), 1);
    i_rx = 1'b1;
    tick(32);
    check("break_released_idle", 32'(o_busy), 0);
    send_frame(8'h7E, even_pbit(8'h7E), 2'b11, 16, 1'b1, 1'b0);
    tick(40);

    // Reset during DATA of 0xC3.
    i_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      i_rx = 1'((8'hC3 >> i) & 8'h01);
      tick(16);
    end
    i_rst = 1'b1;
    #1;
    check("midreset_valid", 32'(o_valid), 0);
    check("midreset_data", 32'(o_data), 0);
    check("midreset_flags", {29'd0, o_parity_err, o_frame_err, o_break}, 0);
    check("midreset_busy", 32'(o_busy), 0);
    i_rx = 1'b1;
    tick(3);
    i_rst = 1'b0;
    tick(16 * 10);
    send_frame(8'h3C, even_pbit(8'h3C), 2'b11, 16, 1'b1, 1'b0);
    tick(40);

    // Enable dropped mid-frame while a word is held.
    ready_mode = 0;
    send_frame(8'h5A, even_pbit(8'h5A), 2'b11, 16, 1'b1, 1'b0);
    tick(8);
    i_rx = 1'b0;
    tick(16);
    i_rx = 1'b1;
    tick(32);
    i_enable = 1'b0;
    tick(1);
    check("enable_drop_idle", 32'(o_busy), 0);
    check("enable_drop_held_valid", 32'(o_valid), 1);
    check("enable_drop_held_data", 32'(o_data), 32'h5A);
    tick(16 * 12);
    i_enable = 1'b1;
    ready_mode = 1;
    tick(5);
    send_frame(8'h81, even_pbit(8'h81), 2'b11, 16, 1'b1, 1'b1);
    tick(40);

    // Random frames: random divisor (including below the minimum), errors, gaps, ready.
    ready_mode = 2;
    for (int k = 0; k < 25; k++) begin
      n  = int'($urandom_range(5, 24));
      nb = (n < 8) ? 8 : n;
      d  = DL'($urandom_range(0, 255));
      pb = ($urandom_range(0, 4) == 0) ? ~even_pbit(d) : even_pbit(d);
      st = ($urandom_range(0, 6) == 0) ? SB'($urandom_range(0, 2)) : {SB{1'b1}};
      send_frame(d, pb, st, n, 1'b1, 1'b1);
      gap = int'($urandom_range(0, 2));
      if (st != {SB{1'b1}} && gap == 0) gap = 1;
      tick(gap * nb);
    end

    ready_mode = 1;
    tick(400);
    check("all_words_delivered", exp_q.size(), 0);
    check("overrun_total", overrun_seen, overrun_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
